// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch/issue stage.
package instr_fetch_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LATCH,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [3:0]  HALT_OPC = 4'hF;
  localparam int unsigned RETIRE_W = 16;

endpackage

// File: rtl/fetch_pc.sv
// Program counter: clear, increment and hold, with terminal-address flag.
module fetch_pc #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned PROG_LEN = 256
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc,
  output logic              last
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PROG_LEN - 1);

  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      pc <= '0;
    end else if (inc) begin
      pc <= pc + 1'b1;
    end
  end

  assign last = (pc == LAST_ADDR);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch/issue stage feeding the control FSM.
// Optional opcode-halt behaviour is enabled by defining INSTR_FETCH_HALT_EN.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned INSTR_W  = 16,
  parameter int unsigned PROG_LEN = 256
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                Run,
  input  logic                Ready,
  input  logic                Wen,
  input  logic [INSTR_W-1:0]  MemData,
  output logic [ADDR_W-1:0]   MemAddr,
  output logic                Start,
  output logic [INSTR_W-1:0]  Instr,
  output logic [ADDR_W-1:0]   Pc,
  output logic                Busy,
  output logic                Done,
  output logic [RETIRE_W-1:0] RetireCnt
);

  state_t state, state_nxt;

  logic                run_q;
  logic                run_rise;
  logic                is_halt;
  logic                pc_clr;
  logic                pc_inc;
  logic                pc_last;
  logic                capture;
  logic                issue;
  logic                retire;
  logic [ADDR_W-1:0]   pc;
  logic [INSTR_W-1:0]  instr_q;
  logic                start_q;
  logic [RETIRE_W-1:0] retire_cnt;

  assign run_rise = Run & ~run_q;

`ifdef INSTR_FETCH_HALT_EN
  assign is_halt = (MemData[INSTR_W-1 -: 4] == HALT_OPC);
`else
  assign is_halt = 1'b0;
`endif

  fetch_pc #(
    .ADDR_W   (ADDR_W),
    .PROG_LEN (PROG_LEN)
  ) u_pc (
    .CLK  (CLK),
    .RST  (RST),
    .clr  (pc_clr),
    .inc  (pc_inc),
    .pc   (pc),
    .last (pc_last)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (Run) state_nxt = S_ADDR;
      S_ADDR:  state_nxt = S_LATCH;
      S_LATCH: state_nxt = is_halt ? S_DONE : S_ISSUE;
      S_ISSUE: if (Ready) state_nxt = S_WAIT;
      // Ready is deliberately ignored here; only the write-back pulse retires.
      S_WAIT: begin
        if (Wen) begin
          if (pc_last)  state_nxt = S_DONE;
          else if (Run) state_nxt = S_ADDR;
          else          state_nxt = S_IDLE;
        end
      end
      S_DONE:  if (run_rise) state_nxt = S_ADDR;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    pc_clr  = 1'b0;
    pc_inc  = 1'b0;
    capture = 1'b0;
    issue   = 1'b0;
    retire  = 1'b0;
    Busy    = 1'b1;
    Done    = 1'b0;
    unique case (state)
      S_IDLE:  Busy = 1'b0;
      S_ADDR:  ;
      S_LATCH: capture = 1'b1;
      S_ISSUE: issue = Ready;
      S_WAIT: begin
        retire = Wen;
        pc_inc = Wen & ~pc_last;
      end
      S_DONE: begin
        Busy   = 1'b0;
        Done   = 1'b1;
        pc_clr = run_rise;
      end
      default: Busy = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      run_q      <= 1'b0;
      instr_q    <= '0;
      start_q    <= 1'b0;
      retire_cnt <= '0;
    end else begin
      run_q   <= Run;
      start_q <= issue;
      if (capture) instr_q <= MemData;
      if (retire)  retire_cnt <= retire_cnt + 1'b1;
    end
  end

  assign MemAddr   = pc;
  assign Pc        = pc;
  assign Instr     = instr_q;
  assign Start     = start_q;
  assign RetireCnt = retire_cnt;

endmodule
